// File: rtl/l1_threshold_loader.sv
// Wishbone host for the L1 beam trigger block. It writes the beam thresholds and CE flags,
// issues the global update, takes a count snapshot and reads back every beam count.
module l1_threshold_loader #(
  parameter int unsigned NBEAMS     = 2,
  parameter logic [21:0] TRIG_BASE  = 22'h002000,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned POLL_LIMIT = 1023,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start_i,
  input  logic [NBEAMS*18-1:0]   thresh_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [1:0]             fail_code_o,
  output logic [NBEAMS*32-1:0]   count_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [21:0]            wb_adr_o,
  output logic [31:0]            wb_dat_o,
  output logic [3:0]             wb_sel_o,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i,
  input  logic                   wb_rty_i,
  input  logic [31:0]            wb_dat_i
);

  localparam int unsigned BW = (NBEAMS > 1)     ? $clog2(NBEAMS)         : 1;
  localparam int unsigned TW = (TIMEOUT > 1)    ? $clog2(TIMEOUT + 1)    : 1;
  localparam int unsigned PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0)  ? $clog2(MAX_RETRY + 2)  : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_THR_WR, S_CE_WR, S_UPD_WR, S_REQ_WR, S_POLL_RD, S_CNT_RD, S_DONE, S_FAIL
  } state_e;

  state_e                     state_q, state_d, iss_st;
  logic [BW-1:0]              beam_q, beam_d, iss_beam;
  logic                       cyc_q, cyc_d, we_q, we_d, iss_we;
  logic [21:0]                adr_q, adr_d, iss_adr;
  logic [31:0]                dat_q, dat_d, iss_dat;
  logic [3:0]                 sel_q, sel_d, iss_sel;
  logic [17:0]                iss_thr;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic [PW-1:0]              poll_q, poll_d;
  logic [RW-1:0]              retry_q, retry_d;
  logic                       busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [1:0]                 code_q, code_d;
  logic [NBEAMS-1:0][17:0]    thr_in, thr_q, thr_d;
  logic [NBEAMS-1:0][31:0]    shadow_q, shadow_d, count_q, count_d;
  logic                       last_beam;

  assign thr_in    = thresh_i;
  assign last_beam = (beam_q == BW'(NBEAMS - 1));

  // Bus fields for the transaction about to be issued; from IDLE that is THR_WR(0).
  always_comb begin
    iss_st   = (state_q == S_IDLE) ? S_THR_WR : state_q;
    iss_beam = (state_q == S_IDLE) ? '0 : beam_q;
    iss_thr  = (state_q == S_IDLE) ? thr_in[0] : thr_q[beam_q];
    iss_adr  = TRIG_BASE;
    iss_dat  = '0;
    iss_sel  = 4'b1111;
    iss_we   = 1'b0;
    case (iss_st)
      S_THR_WR: begin
        iss_adr = TRIG_BASE | 22'h000100 | 22'(iss_beam);
        iss_dat = {14'b0, iss_thr};
        iss_sel = 4'b0111;
        iss_we  = 1'b1;
      end
      S_CE_WR: begin
        iss_adr = TRIG_BASE | 22'h000200 | 22'(iss_beam);
        iss_dat = 32'h1;
        iss_sel = 4'b0011;
        iss_we  = 1'b1;
      end
      S_UPD_WR: begin
        iss_dat = 32'h2;
        iss_sel = 4'b0010;
        iss_we  = 1'b1;
      end
      S_REQ_WR: begin
        iss_dat = 32'h1;
        iss_sel = 4'b0001;
        iss_we  = 1'b1;
      end
      S_CNT_RD: iss_adr = TRIG_BASE | 22'h000100 | 22'(iss_beam);
      default: ;
    endcase
  end

  // Sequencer: issue on an idle bus cycle, then resolve err > rty > ack > timeout.
  always_comb begin
    state_d  = state_q;
    beam_d   = beam_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    tmo_d    = tmo_q;
    poll_d   = poll_q;
    retry_d  = retry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    code_d   = code_q;
    thr_d    = thr_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          thr_d   = thr_in;
          beam_d  = '0;
          state_d = S_THR_WR;
          busy_d  = 1'b1;
          code_d  = 2'd0;
          retry_d = '0;
          poll_d  = '0;
          tmo_d   = '0;
          cyc_d   = 1'b1;
          we_d    = iss_we;
          adr_d   = iss_adr;
          dat_d   = iss_dat;
          sel_d   = iss_sel;
        end
      end
      S_DONE: begin
        count_d = shadow_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        fail_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = iss_we;
          adr_d = iss_adr;
          dat_d = iss_dat;
          sel_d = iss_sel;
          tmo_d = '0;
        end else if (wb_err_i) begin
          cyc_d   = 1'b0;
          code_d  = 2'd1;
          state_d = S_FAIL;
        end else if (wb_rty_i) begin
          cyc_d = 1'b0;
          if (retry_q >= RW'(MAX_RETRY)) begin
            code_d  = 2'd3;
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + RW'(1);
          end
        end else if (wb_ack_i) begin
          cyc_d   = 1'b0;
          retry_d = '0;
          case (state_q)
            S_THR_WR: state_d = S_CE_WR;
            S_CE_WR: begin
              state_d = last_beam ? S_UPD_WR : S_THR_WR;
              beam_d  = last_beam ? '0 : beam_q + BW'(1);
            end
            S_UPD_WR: state_d = S_REQ_WR;
            S_REQ_WR: begin
              state_d = S_POLL_RD;
              poll_d  = '0;
            end
            S_POLL_RD: begin
              if (wb_dat_i[0]) begin
                state_d = S_CNT_RD;
                beam_d  = '0;
              end else if (poll_q >= PW'(POLL_LIMIT - 1)) begin
                code_d  = 2'd3;
                state_d = S_FAIL;
              end else begin
                poll_d = poll_q + PW'(1);
              end
            end
            S_CNT_RD: begin
              shadow_d[beam_q] = wb_dat_i;
              state_d = last_beam ? S_DONE : S_CNT_RD;
              beam_d  = last_beam ? '0 : beam_q + BW'(1);
            end
            default: ;
          endcase
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          code_d  = 2'd2;
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      beam_q   <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      tmo_q    <= '0;
      poll_q   <= '0;
      retry_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      code_q   <= '0;
      thr_q    <= '0;
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      beam_q   <= beam_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      tmo_q    <= tmo_d;
      poll_q   <= poll_d;
      retry_q  <= retry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      thr_q    <= thr_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_code_o = code_q;
  assign count_o     = count_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;

endmodule

// File: tb/tb_l1_threshold_loader.sv
// Bench for l1_threshold_loader: behavioural Wishbone target plus an expected-transaction queue.
module tb_l1_threshold_loader;

  typedef struct packed {
    logic [21:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [35:0] thresh_i = '0;
  logic        busy_o, done_o, fail_o;
  logic [1:0]  fail_code_o;
  logic [63:0] count_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [21:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic [31:0] wb_dat_i = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int   step_idx, err_at, hang_at, rty_at, rty_rem, poll_zero;
  logic poll_never;
  logic [31:0] cnt_val [2];
  logic cyc_prev = 1'b0;
  int   cyc_hi_cnt = 0;

  int   ncyc;
  logic got_done, got_fail, busy_at_end, cyc_c1;

  l1_threshold_loader #(
    .NBEAMS(2), .TRIG_BASE(22'h002000), .TIMEOUT(255), .POLL_LIMIT(4), .MAX_RETRY(3)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .thresh_i(thresh_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_code_o(fail_code_o),
    .count_o(count_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [21:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat);
    exp_t e;
    e.adr = adr; e.we = we; e.sel = sel; e.dat = we ? dat : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic push_writes(input logic [35:0] th);
    push_tx(22'h002100, 1'b1, 4'b0111, {14'b0, th[17:0]});
    push_tx(22'h002200, 1'b1, 4'b0011, 32'h1);
    push_tx(22'h002101, 1'b1, 4'b0111, {14'b0, th[35:18]});
    push_tx(22'h002201, 1'b1, 4'b0011, 32'h1);
    push_tx(22'h002000, 1'b1, 4'b0010, 32'h2);
    push_tx(22'h002000, 1'b1, 4'b0001, 32'h1);
  endtask

  task automatic push_reads(input int npoll);
    for (int i = 0; i < npoll; i++) push_tx(22'h002000, 1'b0, 4'b1111, 32'h0);
    push_tx(22'h002100, 1'b0, 4'b1111, 32'h0);
    push_tx(22'h002101, 1'b0, 4'b1111, 32'h0);
  endtask

  task automatic reset_knobs();
    step_idx = 0; err_at = -1; hang_at = -1; rty_at = -1; rty_rem = 0;
    poll_zero = 0; poll_never = 1'b0;
  endtask

  task automatic run_seq(input logic [35:0] th, input int budget);
    @(negedge clk);
    thresh_i = th;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cyc_c1  = wb_cyc_o;
    ncyc = 0; got_done = 1'b0; got_fail = 1'b0; busy_at_end = 1'b1;
    while (!got_done && !got_fail && ncyc < budget) begin
      @(posedge clk);
      #1;
      ncyc++;
      if (done_o || fail_o) busy_at_end = busy_o;
      if (done_o) got_done = 1'b1;
      if (fail_o) got_fail = 1'b1;
      if (done_o && fail_o) chk("done_fail_exclusive", 64'(done_o & fail_o), 64'h0);
    end
  endtask

  // Target model: decides the termination for each new transaction and checks it against the queue.
  always @(negedge clk) begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
    if (wb_cyc_o && wb_stb_o && !cyc_prev) begin
      exp_t e, o;
      cyc_hi_cnt = 1;
      chk("tx_expected", 64'(exp_q.size() != 0), 64'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        o.adr = wb_adr_o; o.we = wb_we_o; o.sel = wb_sel_o; o.dat = wb_we_o ? wb_dat_o : 32'h0;
        chk("tx_fields", 64'(o), 64'(e));
      end
      if (step_idx == err_at) wb_err_i = 1'b1;
      else if (step_idx == hang_at) ;
      else if (step_idx == rty_at && rty_rem > 0) begin
        wb_rty_i = 1'b1;
        rty_rem--;
      end else begin
        wb_ack_i = 1'b1;
        step_idx++;
        if (!wb_we_o) begin
          if (wb_adr_o == 22'h002000) begin
            if (poll_never || poll_zero > 0) begin
              wb_dat_i = 32'h0;
              poll_zero--;
            end else wb_dat_i = 32'h1;
          end else wb_dat_i = cnt_val[wb_adr_o[0]];
        end
      end
    end else if (wb_cyc_o) cyc_hi_cnt++;
    cyc_prev = wb_cyc_o;
  end

  initial begin
    logic [35:0] th_nom;
    th_nom = {18'h00123, 18'h2ABCD};
    reset_knobs();
    cnt_val[0] = 32'd100; cnt_val[1] = 32'd200;

    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_done_fail", 64'({done_o, fail_o}), 64'h0);
    chk("rst_code", 64'(fail_code_o), 64'h0);
    chk("rst_count", count_o, 64'h0);
    chk("rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal run
    push_writes(th_nom); push_reads(1);
    run_seq(th_nom, 100);
    chk("nom_cyc_at_cycle1", 64'(cyc_c1), 64'h1);
    chk("nom_done", 64'({got_done, got_fail}), 64'h2);
    chk("nom_latency", 64'(ncyc + 1), 64'd19);
    chk("nom_busy_falls", 64'(busy_at_end), 64'h0);
    chk("nom_count", count_o, {32'd200, 32'd100});
    chk("nom_code", 64'(fail_code_o), 64'h0);
    chk("nom_queue_drained", 64'(exp_q.size()), 64'h0);

    // Status polls three times before the snapshot completes
    reset_knobs(); poll_zero = 3;
    cnt_val[0] = 32'd300; cnt_val[1] = 32'd400;
    push_writes(th_nom); push_reads(4);
    run_seq(th_nom, 100);
    chk("poll_done", 64'({got_done, got_fail}), 64'h2);
    chk("poll_count", count_o, {32'd400, 32'd300});
    chk("poll_queue_drained", 64'(exp_q.size()), 64'h0);

    // Snapshot never completes
    reset_knobs(); poll_never = 1'b1;
    cnt_val[0] = 32'd7; cnt_val[1] = 32'd8;
    push_writes(th_nom);
    for (int i = 0; i < 4; i++) push_tx(22'h002000, 1'b0, 4'b1111, 32'h0);
    run_seq(th_nom, 100);
    chk("plim_fail", 64'({got_done, got_fail}), 64'h1);
    chk("plim_code", 64'(fail_code_o), 64'h3);
    chk("plim_count_kept", count_o, {32'd400, 32'd300});
    chk("plim_queue_drained", 64'(exp_q.size()), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("plim_code_held", 64'(fail_code_o), 64'h3);

    // No response on the second write
    reset_knobs(); hang_at = 1;
    push_tx(22'h002100, 1'b1, 4'b0111, {14'b0, th_nom[17:0]});
    push_tx(22'h002200, 1'b1, 4'b0011, 32'h1);
    run_seq(th_nom, 400);
    chk("tmo_fail", 64'({got_done, got_fail}), 64'h1);
    chk("tmo_code", 64'(fail_code_o), 64'h2);
    chk("tmo_cyc_cycles", 64'(cyc_hi_cnt), 64'd255);
    chk("tmo_queue_drained", 64'(exp_q.size()), 64'h0);

    // err on CE_WR(0)
    reset_knobs(); err_at = 1;
    push_tx(22'h002100, 1'b1, 4'b0111, {14'b0, th_nom[17:0]});
    push_tx(22'h002200, 1'b1, 4'b0011, 32'h1);
    run_seq(th_nom, 100);
    chk("err_fail", 64'({got_done, got_fail}), 64'h1);
    chk("err_code", 64'(fail_code_o), 64'h1);
    chk("err_queue_drained", 64'(exp_q.size()), 64'h0);

    // Two retries then ack on the first write
    reset_knobs(); rty_at = 0; rty_rem = 2;
    cnt_val[0] = 32'd500; cnt_val[1] = 32'd600;
    push_tx(22'h002100, 1'b1, 4'b0111, {14'b0, th_nom[17:0]});
    push_tx(22'h002100, 1'b1, 4'b0111, {14'b0, th_nom[17:0]});
    push_writes(th_nom); push_reads(1);
    run_seq(th_nom, 100);
    chk("rty2_done", 64'({got_done, got_fail}), 64'h2);
    chk("rty2_code_cleared", 64'(fail_code_o), 64'h0);
    chk("rty2_count", count_o, {32'd600, 32'd500});
    chk("rty2_queue_drained", 64'(exp_q.size()), 64'h0);

    // Four retries exceed the limit
    reset_knobs(); rty_at = 0; rty_rem = 4;
    for (int i = 0; i < 4; i++) push_tx(22'h002100, 1'b1, 4'b0111, {14'b0, th_nom[17:0]});
    run_seq(th_nom, 100);
    chk("rty4_fail", 64'({got_done, got_fail}), 64'h1);
    chk("rty4_code", 64'(fail_code_o), 64'h3);
    chk("rty4_queue_drained", 64'(exp_q.size()), 64'h0);

    // Reset while a transaction is open
    reset_knobs(); hang_at = 3;
    push_writes(th_nom);
    @(negedge clk);
    thresh_i = th_nom; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    ncyc = 0;
    while (!(wb_cyc_o && step_idx >= 3) && ncyc < 50) begin
      @(posedge clk);
      #1 ncyc++;
    end
    chk("mid_cyc_open", 64'(wb_cyc_o), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_cyc_stb_drop", 64'({wb_cyc_o, wb_stb_o}), 64'h0);
    chk("mid_busy", 64'(busy_o), 64'h0);
    got_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done_o || fail_o) got_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("mid_no_pulse", 64'(got_done), 64'h0);
    chk("mid_count_cleared", count_o, 64'h0);
    exp_q.delete();

    reset_knobs();
    cnt_val[0] = 32'd100; cnt_val[1] = 32'd200;
    push_writes(th_nom); push_reads(1);
    run_seq(th_nom, 100);
    chk("post_rst_done", 64'({got_done, got_fail}), 64'h2);
    chk("post_rst_latency", 64'(ncyc + 1), 64'd19);
    chk("post_rst_count", count_o, {32'd200, 32'd100});
    chk("post_rst_queue_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
